// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP controller.
// State encoding follows the conventional 1149.1 4-bit assignment.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_t;

  localparam logic [1:0] IR_CAPTURE = 2'b01;
  localparam int         IDCODE_LEN = 32;

  // All-ones opcode for an instruction register of the given width.
  function automatic logic [31:0] bypass_op(input int ir_length);
    if (ir_length >= 32) return '1;
    return (32'd1 << ir_length) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 1149.1 TAP state machine: TMS next-state logic, state register and
// the DR strobes decoded purely from the state register.
//
// state  | meaning
// TLR    | test-logic-reset, instruction forced to IDCODE
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | capture into selected DR
// SH_DR  | shift selected DR
// EX1_DR | exit1 DR
// PA_DR  | pause DR, shift registers hold
// EX2_DR | exit2 DR
// UPD_DR | update DR
// SEL_IR | select IR scan
// CAP_IR | capture 0..01 into IR shift register
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PA_IR  | pause IR, shift registers hold
// EX2_IR | exit2 IR
// UPD_IR | shifted IR becomes the current instruction
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t state_nxt,
  output logic       capture,
  output logic       shift,
  output logic       update,
  output logic       reset
);

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:     state_nxt = tms ? TLR    : RTI;
      RTI:     state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms ? UPD_DR : PA_DR;
      PA_DR:   state_nxt = tms ? EX2_DR : PA_DR;
      EX2_DR:  state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms ? UPD_IR : PA_IR;
      PA_IR:   state_nxt = tms ? EX2_IR : PA_IR;
      EX2_IR:  state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TLR;
    else         state <= state_nxt;
  end

  assign capture = (state == CAP_DR);
  assign shift   = (state == SH_DR);
  assign update  = (state == UPD_DR);
  assign reset   = (state == TLR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller exposing a BSCAN-style user interface: holds the IR,
// the IDCODE and BYPASS data registers, and the falling-edge TDO stage.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int                   IR_LENGTH = 6,
  parameter logic [31:0]          IDCODE    = 32'h0167C093,
  parameter logic [IR_LENGTH-1:0] IDCODE_OP = 6'h09,
  parameter logic [IR_LENGTH-1:0] USER_OP   = 6'h02
)(
  input  logic tck,
  input  logic trst_n,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_oe,
  input  logic tdo_user,
  output logic capture,
  output logic shift,
  output logic update,
  output logic reset,
  output logic sel,
  output logic drck_en,
  output logic tdi_user
);

  localparam logic [IR_LENGTH-1:0] BYPASS_OP   = IR_LENGTH'(bypass_op(IR_LENGTH));
  localparam logic [IR_LENGTH-1:0] IR_CAP_VAL  = IR_LENGTH'(IR_CAPTURE);

  tap_state_t state;
  tap_state_t state_nxt;

  logic [IR_LENGTH-1:0]  ir_shift;
  logic [IR_LENGTH-1:0]  ir_cur;
  logic [IDCODE_LEN-1:0] idcode_sr;
  logic                  bypass_sr;
  dr_sel_t               dr_sel;
  logic                  dr_tdo;

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst_n    (trst_n),
    .tms       (tms),
    .state     (state),
    .state_nxt (state_nxt),
    .capture   (capture),
    .shift     (shift),
    .update    (update),
    .reset     (reset)
  );

  // Unknown opcodes fall back to BYPASS, same as the architected all-ones.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_cur == IDCODE_OP)      dr_sel = DR_IDCODE;
    else if (ir_cur == USER_OP)   dr_sel = DR_USER;
    else if (ir_cur == BYPASS_OP) dr_sel = DR_BYPASS;
  end

  // Instruction is forced on the same edge that enters TLR.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_shift <= '0;
      ir_cur   <= IDCODE_OP;
    end else begin
      if (state == CAP_IR)     ir_shift <= IR_CAP_VAL;
      else if (state == SH_IR) ir_shift <= {tdi, ir_shift[IR_LENGTH-1:1]};

      if (state_nxt == TLR)     ir_cur <= IDCODE_OP;
      else if (state == UPD_IR) ir_cur <= ir_shift;
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
    end else if (state == CAP_DR) begin
      if (dr_sel == DR_IDCODE) idcode_sr <= IDCODE;
      if (dr_sel == DR_BYPASS) bypass_sr <= 1'b0;
    end else if (state == SH_DR) begin
      if (dr_sel == DR_IDCODE) idcode_sr <= {tdi, idcode_sr[IDCODE_LEN-1:1]};
      if (dr_sel == DR_BYPASS) bypass_sr <= tdi;
    end
  end

  always_comb begin
    dr_tdo = bypass_sr;
    case (dr_sel)
      DR_IDCODE: dr_tdo = idcode_sr[0];
      DR_USER:   dr_tdo = tdo_user;
      default:   dr_tdo = bypass_sr;
    endcase
  end

  // TDO holds its last bit outside the shift states; only the enable drops.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else begin
      tdo_oe <= 1'b0;
      if (state == SH_IR) begin
        tdo    <= ir_shift[0];
        tdo_oe <= 1'b1;
      end else if (state == SH_DR) begin
        tdo    <= dr_tdo;
        tdo_oe <= 1'b1;
      end
    end
  end

  assign sel      = (ir_cur == USER_OP);
  assign drck_en  = sel & (capture | shift);
  assign tdi_user = tdi;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl with a queue-based reference model of
// the TAP, compared on every falling edge, plus literal scan results.
module tb_jtag_tap_ctrl;

  localparam int          IRL  = 6;
  localparam logic [31:0] IDC  = 32'h0167C093;
  localparam logic [5:0]  IDOP = 6'h09;
  localparam logic [5:0]  USOP = 6'h02;

  // model state numbering (independent of the RTL encoding)
  localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHDR = 4, T_E1D = 5,
                 T_PDR = 6, T_E2D = 7, T_UDR = 8, T_SIR = 9, T_CIR = 10, T_SHIR = 11,
                 T_E1I = 12, T_PIR = 13, T_E2I = 14, T_UIR = 15;
  localparam int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  localparam int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic tck = 1'b0;
  logic trst_n, tms, tdi, tdo_user;
  logic tdo, tdo_oe, capture, shift, update, reset, sel, drck_en, tdi_user;

  jtag_tap_ctrl #(
    .IR_LENGTH (IRL),
    .IDCODE    (IDC),
    .IDCODE_OP (IDOP),
    .USER_OP   (USOP)
  ) dut (
    .tck      (tck),
    .trst_n   (trst_n),
    .tms      (tms),
    .tdi      (tdi),
    .tdo      (tdo),
    .tdo_oe   (tdo_oe),
    .tdo_user (tdo_user),
    .capture  (capture),
    .shift    (shift),
    .update   (update),
    .reset    (reset),
    .sel      (sel),
    .drck_en  (drck_en),
    .tdi_user (tdi_user)
  );

  always #5 tck = ~tck;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model
  int          m_state;
  logic [5:0]  m_ir;
  bit          irq[$];
  bit          idq[$];
  bit          bpq;
  logic        e_tdo = 1'b0;
  logic        e_oe  = 1'b0;
  logic [31:0] idc_v = IDC;

  function automatic void model_reset();
    m_state = T_TLR;
    m_ir    = IDOP;
    irq.delete();
    idq.delete();
    for (int i = 0; i < IRL; i++) irq.push_back(1'b0);
    for (int i = 0; i < 32; i++) idq.push_back(1'b0);
    bpq = 1'b0;
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) model_reset();
    else begin : mdl
      int cur;
      cur = m_state;
      if (cur == T_CIR) begin
        irq.delete();
        irq.push_back(1'b1);
        for (int i = 1; i < IRL; i++) irq.push_back(1'b0);
      end else if (cur == T_SHIR) begin
        void'(irq.pop_front());
        irq.push_back(tdi);
      end else if (cur == T_UIR) begin
        for (int i = 0; i < IRL; i++) m_ir[i] = irq[i];
      end else if (cur == T_CDR) begin
        if (m_ir == IDOP) begin
          idq.delete();
          for (int i = 0; i < 32; i++) idq.push_back(idc_v[i]);
        end else if (m_ir != USOP) bpq = 1'b0;
      end else if (cur == T_SHDR) begin
        if (m_ir == IDOP) begin
          void'(idq.pop_front());
          idq.push_back(tdi);
        end else if (m_ir != USOP) bpq = tdi;
      end
      m_state = tms ? NXT1[cur] : NXT0[cur];
      if (m_state == T_TLR) m_ir = IDOP;
    end
  end

  always @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      e_tdo = 1'b0;
      e_oe  = 1'b0;
    end else begin
      e_oe = 1'b0;
      if (m_state == T_SHIR) begin
        e_tdo = irq[0];
        e_oe  = 1'b1;
      end else if (m_state == T_SHDR) begin
        e_oe = 1'b1;
        if (m_ir == IDOP)      e_tdo = idq[0];
        else if (m_ir == USOP) e_tdo = tdo_user;
        else                   e_tdo = bpq;
      end
    end
  end

  always @(negedge tck) begin
    #1;
    if (chk_en && trst_n) begin
      chk1("reset",    reset,    m_state == T_TLR);
      chk1("capture",  capture,  m_state == T_CDR);
      chk1("shift",    shift,    m_state == T_SHDR);
      chk1("update",   update,   m_state == T_UDR);
      chk1("sel",      sel,      m_ir == USOP);
      chk1("drck_en",  drck_en,  (m_ir == USOP) && (m_state == T_CDR || m_state == T_SHDR));
      chk1("tdo_oe",   tdo_oe,   e_oe);
      chk1("tdo",      tdo,      e_tdo);
      chk1("tdi_user", tdi_user, tdi);
    end
  end

  int n_drck = 0;
  int n_upd  = 0;
  always @(negedge tck) begin
    #1;
    if (drck_en === 1'b1) n_drck++;
    if (update === 1'b1)  n_upd++;
  end

  // stimulus: inputs change 2 time units after the rising edge
  task automatic step(input logic t, input logic d, input logic u, output logic seen);
    tms = t; tdi = d; tdo_user = u;
    @(negedge tck);
    #1 seen = tdo;
    @(posedge tck);
    #2;
  endtask

  task automatic stp(input logic t, input logic d);
    logic s;
    step(t, d, 1'b0, s);
  endtask

  task automatic goto_shdr();
    stp(1, 0); stp(0, 0); stp(0, 0);
  endtask

  task automatic goto_shir();
    stp(1, 0); stp(1, 0); stp(0, 0); stp(0, 0);
  endtask

  task automatic load_ir(input logic [5:0] op, output logic [5:0] cap);
    logic b;
    goto_shir();
    for (int i = 0; i < IRL; i++) begin
      step(i == IRL - 1, op[i], 1'b0, b);
      cap[i] = b;
    end
    stp(1, 0); stp(0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] v32;
  logic [5:0]  v6;
  logic [7:0]  v8;
  logic [3:0]  v4;
  logic [1:0]  v2;
  logic        b;
  logic [7:0]  upat  = 8'b1011_0010;
  logic [3:0]  bpat  = 4'b1101;

  initial begin
    model_reset();
    trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; tdo_user = 1'b0;
    @(posedge tck); #2;
    chk1("rst_reset",   reset,   1'b1);
    chk1("rst_tdo",     tdo,     1'b0);
    chk1("rst_tdo_oe",  tdo_oe,  1'b0);
    chk1("rst_capture", capture, 1'b0);
    chk1("rst_shift",   shift,   1'b0);
    chk1("rst_update",  update,  1'b0);
    chk1("rst_sel",     sel,     1'b0);
    chk1("rst_drck_en", drck_en, 1'b0);
    trst_n = 1'b1;
    chk_en = 1'b1;
    stp(0, 0);
    chk1("rti_reset", reset, 1'b0);

    // IDCODE read straight after reset
    goto_shdr();
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'b0, 1'b0, b);
      v32[i] = b;
    end
    stp(1, 0); stp(0, 0);
    chkv("idcode_read", v32, IDC);

    // IR capture pattern, then BYPASS behaviour
    load_ir(6'h3F, v6);
    chkv("ir_capture", 32'(v6), 32'h01);
    chk1("bypass_sel", sel, 1'b0);
    goto_shdr();
    for (int i = 0; i < 4; i++) begin
      step(i == 3, bpat[i], 1'b0, b);
      v4[i] = b;
    end
    stp(1, 0); stp(0, 0);
    chkv("bypass_tdo", 32'(v4), 32'h0A);

    // USER chain
    load_ir(USOP, v6);
    chk1("user_sel", sel, 1'b1);
    n_drck = 0;
    n_upd  = 0;
    goto_shdr();
    for (int i = 0; i < 8; i++) begin
      step(i == 7, 1'b0, upat[i], b);
      v8[i] = b;
    end
    stp(1, 0); stp(0, 0);
    chkv("user_tdo",     32'(v8), 32'(upat));
    chkv("user_drck_n",  n_drck,  32'd9);
    chkv("user_update_n", n_upd,  32'd1);
    load_ir(IDOP, v6);
    chk1("idcode_sel", sel, 1'b0);

    // TMS=1 in CAP_IR: captured 0..01 becomes current (a BYPASS opcode)
    stp(1, 0); stp(1, 0); stp(0, 0); stp(1, 0); stp(1, 0); stp(0, 0);
    goto_shdr();
    step(1'b0, 1'b1, 1'b0, b); v2[0] = b;
    step(1'b1, 1'b0, 1'b0, b); v2[1] = b;
    stp(1, 0); stp(0, 0);
    chkv("capskip_ir_bypass", 32'(v2), 32'h2);

    // TMS=1 in CAP_DR still reaches UPD_DR
    stp(1, 0); stp(0, 0); stp(1, 0); stp(1, 0);
    chk1("capskip_update", update, 1'b1);
    stp(0, 0);

    // five TMS=1 from SH_IR reach TLR
    load_ir(USOP, v6);
    goto_shir();
    for (int k = 1; k <= 5; k++) begin
      stp(1, 0);
      if (k == 4) chk1("tlr_not_yet", reset, 1'b0);
    end
    chk1("tlr_reset", reset, 1'b1);
    chk1("tlr_sel",   sel,   1'b0);
    stp(0, 0);

    // IDCODE read with a pause in the middle
    goto_shdr();
    for (int i = 0; i < 16; i++) begin
      step(i == 15, 1'b0, 1'b0, b);
      v32[i] = b;
    end
    stp(0, 0);
    chk1("pause_tdo_oe", tdo_oe, 1'b0);
    stp(0, 0); stp(1, 0); stp(0, 0);
    for (int i = 16; i < 32; i++) begin
      step(i == 31, 1'b0, 1'b0, b);
      v32[i] = b;
    end
    stp(1, 0); stp(0, 0);
    chkv("idcode_pause", v32, IDC);

    // asynchronous reset in the middle of a USER DR shift
    load_ir(USOP, v6);
    goto_shdr();
    stp(0, 1); stp(0, 0);
    chk1("pre_rst_oe",  tdo_oe, 1'b1);
    chk1("pre_rst_sel", sel,    1'b1);
    trst_n = 1'b0;
    #1;
    chk1("arst_reset",  reset,  1'b1);
    chk1("arst_sel",    sel,    1'b0);
    chk1("arst_tdo_oe", tdo_oe, 1'b0);
    chk1("arst_shift",  shift,  1'b0);
    #1 trst_n = 1'b1;
    stp(0, 0);
    chk1("post_rst_reset", reset, 1'b0);
    chk1("post_rst_sel",   sel,   1'b0);
    stp(0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
